// File: rtl/lock_pkg.sv
// Shared types, default parameters and the tolerance compare used by the
// canal lock chamber controller and its gate logic.
package lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADJ_L  = 3'd1,
    S_ADJ_R  = 3'd2,
    S_OPEN_L = 3'd3,
    S_OPEN_R = 3'd4
  } lock_state_t;

  localparam int LOCK_W           = 8;
  localparam int LOCK_TOL         = 3;
  localparam int LOCK_RATE        = 4;
  localparam int LOCK_RESET_LEVEL = 50;

  // |a - b| <= tol on zero-extended operands; the extra bit keeps the
  // difference from wrapping for any level width up to 32.
  function automatic logic abs_diff_le(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic [31:0] tol);
    logic [32:0] diff;
    if (a >= b) diff = {1'b0, a} - {1'b0, b};
    else        diff = {1'b0, b} - {1'b0, a};
    return diff <= {1'b0, tol};
  endfunction

endpackage

// File: rtl/lock_step_timer.sv
// Level-step prescaler: counts 0..RATE-1 while enabled and emits a one-cycle
// step pulse on the last count; clear holds the count at zero.
module lock_step_timer #(
  parameter int RATE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic step_o
);

  localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    step_o = 1'b0;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        step_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lock_level_ctrl.sv
// Chamber water controller: drives the chamber level toward the requested
// side's level, then opens that gate until the gondola reports clear.
module lock_level_ctrl
  import lock_pkg::*;
#(
  parameter int W           = LOCK_W,
  parameter int TOL         = LOCK_TOL,
  parameter int RATE        = LOCK_RATE,
  parameter int RESET_LEVEL = LOCK_RESET_LEVEL
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_left,
  input  logic         req_right,
  input  logic [W-1:0] left_level,
  input  logic [W-1:0] right_level,
  input  logic         gondola_clear,
  output logic [W-1:0] chamber_level,
  output logic         fill,
  output logic         drain,
  output logic         open_left,
  output logic         open_right,
  output logic         busy
);

  localparam logic [W-1:0] LVL_MAX = '1;

  lock_state_t  state_q, state_d;
  logic [W-1:0] level_q, level_d;
  logic [W-1:0] target;
  logic         adj, matched, below, above, step;

  // Target follows the side being served and is read live every cycle.
  always_comb begin
    target  = (state_q == S_ADJ_R || state_q == S_OPEN_R) ? right_level : left_level;
    matched = abs_diff_le(32'(level_q), 32'(target), 32'(TOL));
    adj     = (state_q == S_ADJ_L) || (state_q == S_ADJ_R);
    below   = level_q < target;
    above   = level_q > target;
  end

  lock_step_timer #(.RATE(RATE)) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (!adj),
    .en_i   (adj && !matched),
    .step_o (step)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_left)       state_d = S_ADJ_L;
        else if (req_right) state_d = S_ADJ_R;
      end
      S_ADJ_L, S_ADJ_R: begin
        if (matched) begin
          state_d = (state_q == S_ADJ_L) ? S_OPEN_L : S_OPEN_R;
        end else if (step) begin
          // Saturation is a safety net; an in-range target never hits it.
          if (below && level_q != LVL_MAX)  level_d = level_q + 1'b1;
          else if (above && level_q != '0)  level_d = level_q - 1'b1;
        end
      end
      S_OPEN_L, S_OPEN_R: begin
        if (gondola_clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      level_q <= W'(RESET_LEVEL);
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  assign chamber_level = level_q;
  assign fill          = adj && !matched && below;
  assign drain         = adj && !matched && above;
  assign open_left     = (state_q == S_OPEN_L);
  assign open_right    = (state_q == S_OPEN_R);
  assign busy          = (state_q != S_IDLE);

endmodule
